fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_WIDTH, 64, PC and address width.
  INST_WIDTH, 32, instruction word width.
  RESET_PC, 0, first fetch address after reset.
  BUF_DEPTH, 2, instruction buffer entries (power of two, >= 2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, single clock; all state updates on the rising edge.
  reset, in, 1, synchronous, active-high.
  redir_valid, in, 1, redirect from execute (branch/jal/jalr already resolved).
  redir_addr, in, ADDR_WIDTH, redirect target.
  imem_req_valid, out, 1, fetch request valid.
  imem_req_addr, out, ADDR_WIDTH, fetch address.
  imem_req_ready, in, 1, memory accepts the request.
  imem_rsp_valid, in, 1, response valid, one per accepted request, in order.
  imem_rsp_data, in, INST_WIDTH, fetched word.
  d_valid, out, 1, decode entry valid.
  d_ready, in, 1, decode consumes the entry.
  d_pc, out, ADDR_WIDTH, PC of the head entry.
  d_pc4, out, ADDR_WIDTH, d_pc+4.
  d_inst_word, out, INST_WIDTH, instruction of the head entry.
  inst_buffer_empty, out, 1, buffer holds 0 entries.
  inst_buffer_full, out, 1, buffer holds BUF_DEPTH entries.

Function
REQ-003 FSM states SHALL be REQ, WAIT and DRAIN; at most one request SHALL be outstanding.
REQ-004 In REQ, imem_req_valid SHALL equal (count + 0 < BUF_DEPTH), and imem_req_addr SHALL equal fetch_pc.
REQ-005 A handshake (req_valid && req_ready) SHALL latch inflight_pc = fetch_pc, set fetch_pc += 4 (mod 2^ADDR_WIDTH) and move to WAIT.
REQ-006 In WAIT, imem_rsp_valid SHALL push {inflight_pc, imem_rsp_data} into the buffer and move to REQ in the same edge.
REQ-007 A request SHALL be issued only when a free slot is guaranteed at response time; a push into a full buffer SHALL never occur.
REQ-008 d_valid SHALL equal !inst_buffer_empty, with head fields driven combinationally; a pop SHALL occur on d_valid && d_ready.
REQ-009 A push and a pop in the same cycle SHALL leave the count unchanged; pointers SHALL wrap modulo BUF_DEPTH.
REQ-010 On redir_valid: fetch_pc = {redir_addr[ADDR_WIDTH-1:2], 2'b00}; the buffer SHALL be flushed (count = 0); any same-cycle push and pop SHALL be dropped.
REQ-011 Redirect in REQ without a handshake SHALL stay in REQ; imem_req_addr SHALL change to the new target the next cycle (the only permitted address change while req_valid is high).
REQ-012 Redirect in REQ with a same-cycle handshake SHALL move to DRAIN.
REQ-013 Redirect in WAIT without rsp_valid SHALL move to DRAIN; redirect with a same-cycle rsp_valid SHALL discard the response and move to REQ.
REQ-014 In DRAIN, imem_req_valid SHALL be 0; the next rsp_valid SHALL be discarded and the FSM SHALL move to REQ; a redirect in DRAIN SHALL update fetch_pc only.
REQ-015 An imem_rsp_valid in REQ SHALL be ignored.

Reset
REQ-016 While reset is high, the block SHALL set: state = REQ, fetch_pc = RESET_PC, count = 0, pointers = 0, imem_req_valid = 0, d_valid = 0, inst_buffer_empty = 1, inst_buffer_full = 0.
REQ-017 Reset SHALL abandon any outstanding request; the memory side SHALL be reset in the same cycle.
REQ-018 The first request (addr RESET_PC) SHALL be presented in the first cycle after reset deasserts.

Structure
REQ-019 The shared package fetch_pkg SHALL hold fetch_state_t {REQ, WAIT, DRAIN} and the buffer entry struct {pc, inst}.
REQ-020 The buffer SHALL be one sub-module, inst_buffer: a BUF_DEPTH FIFO with a synchronous flush input.

Verification
REQ-021 Reset release, req_ready = 1, rsp one cycle later, d_ready = 1 -> requests at 0x0, 0x4, 0x8; d_pc/d_inst follow in order; d_pc4 = d_pc+4.
REQ-022 d_ready = 0 with BUF_DEPTH = 2 -> exactly 2 entries; inst_buffer_full = 1; req_valid = 0; no third request.
REQ-023 Redirect to 0x103 while in WAIT -> the next response is discarded; the next request is at 0x100; the buffer is empty the cycle after the redirect.
REQ-024 Redirect to 0x200 in the same cycle as rsp_valid -> the response is dropped; the FSM is in REQ; request at 0x200 next cycle.
REQ-025 req_ready held 0 for 5 cycles, then redirect to 0x40 -> req_addr switches to 0x40; the request is accepted later; no DRAIN entered.
REQ-026 fetch_pc = 0xFFFF_FFFF_FFFF_FFFC, handshake -> fetch_pc wraps to 0x0; d_pc4 of that entry = 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch controller.
//   fetch_state_t : fetch FSM states (REQ, WAIT, DRAIN)
//   fetch_entry_t : one instruction buffer entry {pc, inst}
//   FETCH_ADDR_W / FETCH_INST_W : storage widths of a buffer entry
package fetch_pkg;

    localparam int FETCH_ADDR_W = 64;
    localparam int FETCH_INST_W = 32;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction memory request/response channel.
//   imem_req_valid / imem_req_addr : fetch request from the fetch unit
//   imem_req_ready                 : memory accepts the request
//   imem_rsp_valid / imem_rsp_data : one in-order response per accepted request
// Modports: master = fetch unit, slave = instruction memory.
interface fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
);

    logic                  imem_req_valid;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [INST_WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_ctrl_inst_buffer.sv
// inst_buffer: DEPTH-entry FIFO of fetched instructions.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : synchronous flush; drops any same-cycle push and pop
//   push, push_entry : write one entry at the tail
//   pop          : remove the head entry
//   head_entry   : current head (valid when !empty)
//   empty, full  : occupancy flags
module inst_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head_entry,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign do_push    = push && !full && !flush;
    assign do_pop     = pop && !empty && !flush;
    assign head_entry = mem[rd_ptr];

    // Storage array: written only on an accepted push, no reset needed
    // because the pointers and count decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two so the pointers wrap
    // naturally; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with one outstanding memory
// request and a small instruction buffer feeding decode.
//   clk, reset          : clock, synchronous active-high reset
//   redir_valid/addr    : redirect from execute (target is word aligned here)
//   imem                : memory request/response channel (master side)
//   d_valid/d_ready     : decode handshake on the buffer head
//   d_pc, d_pc4, d_inst_word : head entry fields (d_pc4 = d_pc + 4)
//   inst_buffer_empty/full   : buffer occupancy flags
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redir_valid,
    input  logic [ADDR_WIDTH-1:0] redir_addr,
    fetch_ctrl_if.master          imem,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [ADDR_WIDTH-1:0] d_pc,
    output logic [ADDR_WIDTH-1:0] d_pc4,
    output logic [INST_WIDTH-1:0] d_inst_word,
    output logic                  inst_buffer_empty,
    output logic                  inst_buffer_full
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic [ADDR_WIDTH-1:0] redir_target;
    logic                  handshake;
    logic                  buf_push;
    logic                  buf_pop;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;
    logic                  unused_redir_lsbs;

    assign redir_target      = {redir_addr[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redir_lsbs = ^redir_addr[1:0];

    // With at most one request outstanding and none in flight while in REQ,
    // a free slot now is still free when the response returns (the buffer
    // can only drain or flush meanwhile), so "not full" is sufficient.
    assign imem.imem_req_valid = !reset && (state == REQ) && !inst_buffer_full;
    assign imem.imem_req_addr  = fetch_pc;
    assign handshake           = imem.imem_req_valid && imem.imem_req_ready;

    // Only a response to a live request is kept; a redirect in the same
    // cycle turns it into a stale fetch and it is dropped.
    assign buf_push = (state == WAIT) && imem.imem_rsp_valid && !redir_valid;
    assign buf_pop  = d_valid && d_ready;

    // Build the buffer entry from the request address captured at handshake.
    always_comb begin
        push_entry      = '0;
        push_entry.pc   = FETCH_ADDR_W'(inflight_pc);
        push_entry.inst = FETCH_INST_W'(imem.imem_rsp_data);
    end

    // Fetch FSM. DRAIN exists to swallow the response of a request that was
    // already accepted when a redirect made it stale; responses seen in REQ
    // have no matching request and are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (handshake) begin
                        inflight_pc <= fetch_pc;
                        state       <= redir_valid ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        state <= REQ;
                    end else if (redir_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem.imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase

            if (redir_valid) begin
                fetch_pc <= redir_target;
            end else if (handshake) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
        end
    end

    // Instruction buffer; a redirect flushes it and cancels same-cycle
    // push and pop.
    inst_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_inst_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (redir_valid),
        .push       (buf_push),
        .push_entry (push_entry),
        .pop        (buf_pop),
        .head_entry (head_entry),
        .empty      (inst_buffer_empty),
        .full       (inst_buffer_full)
    );

    assign d_valid     = !inst_buffer_empty;
    assign d_pc        = ADDR_WIDTH'(head_entry.pc);
    assign d_pc4       = d_pc + ADDR_WIDTH'(4);
    assign d_inst_word = INST_WIDTH'(head_entry.inst);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Inputs are driven on the falling edge and outputs are checked 1 time
// unit later; each posedge then commits that cycle's inputs.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        redir_valid;
    logic [63:0] redir_addr;
    logic        d_valid;
    logic        d_ready;
    logic [63:0] d_pc;
    logic [63:0] d_pc4;
    logic [31:0] d_inst_word;
    logic        inst_buffer_empty;
    logic        inst_buffer_full;

    int pass_count;
    int check_count;

    fetch_ctrl_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) imem_bus ();

    fetch_ctrl #(
        .ADDR_WIDTH (64),
        .INST_WIDTH (32),
        .RESET_PC   (64'h0),
        .BUF_DEPTH  (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .redir_valid       (redir_valid),
        .redir_addr        (redir_addr),
        .imem              (imem_bus),
        .d_valid           (d_valid),
        .d_ready           (d_ready),
        .d_pc              (d_pc),
        .d_pc4             (d_pc4),
        .d_inst_word       (d_inst_word),
        .inst_buffer_empty (inst_buffer_empty),
        .inst_buffer_full  (inst_buffer_full)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct instruction word for response number n.
    function automatic logic [31:0] inst_of(input int n);
        return 32'hC0DE_0000 + 32'(n);
    endfunction

    // Drive one cycle's inputs on the falling edge, then let them settle.
    task automatic applyStimulus(input logic rv, input logic [63:0] ra,
                                 input logic rdy, input logic rspv,
                                 input logic [31:0] rspd, input logic dr);
        @(negedge clk);
        redir_valid             = rv;
        redir_addr              = ra;
        imem_bus.imem_req_ready = rdy;
        imem_bus.imem_rsp_valid = rspv;
        imem_bus.imem_rsp_data  = rspd;
        d_ready                 = dr;
        #1;
    endtask

    // One comparison against a hand-computed expected value.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        pass_count              = 0;
        check_count             = 0;
        reset                   = 1'b1;
        redir_valid             = 1'b0;
        redir_addr              = '0;
        d_ready                 = 1'b0;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = '0;

        // Reset state while reset is still high.
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
        checkOutput("rst_req_valid", 64'(imem_bus.imem_req_valid), 64'h0);
        checkOutput("rst_d_valid",   64'(d_valid),                 64'h0);
        checkOutput("rst_empty",     64'(inst_buffer_empty),       64'h1);
        checkOutput("rst_full",      64'(inst_buffer_full),        64'h0);
        reset = 1'b0;

        // Streaming fetch: requests 0x0, 0x4, 0x8 with one-cycle responses.
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 1);
        checkOutput("first_req_valid", 64'(imem_bus.imem_req_valid), 64'h1);
        checkOutput("first_req_addr",  imem_bus.imem_req_addr,       64'h0);
        applyStimulus(0, 64'h0, 1, 1, inst_of(0), 1);
        checkOutput("wait_req_valid", 64'(imem_bus.imem_req_valid), 64'h0);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 1);
        checkOutput("req1_addr", imem_bus.imem_req_addr, 64'h4);
        checkOutput("d0_pc",     d_pc,                   64'h0);
        checkOutput("d0_pc4",    d_pc4,                  64'h4);
        checkOutput("d0_inst",   64'(d_inst_word),       64'(inst_of(0)));
        applyStimulus(0, 64'h0, 1, 1, inst_of(1), 1);
        checkOutput("d_valid_after_pop", 64'(d_valid), 64'h0);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 1);
        checkOutput("req2_addr", imem_bus.imem_req_addr, 64'h8);
        checkOutput("d1_pc",     d_pc,                   64'h4);
        checkOutput("d1_inst",   64'(d_inst_word),       64'(inst_of(1)));
        applyStimulus(0, 64'h0, 0, 1, inst_of(2), 0);

        // Decode stalled: buffer fills to two entries, no third request.
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        checkOutput("stall_head_pc", d_pc,                   64'h8);
        checkOutput("req3_addr",     imem_bus.imem_req_addr, 64'hC);
        applyStimulus(0, 64'h0, 1, 1, inst_of(3), 0);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        checkOutput("full_flag",      64'(inst_buffer_full),        64'h1);
        checkOutput("full_req_valid", 64'(imem_bus.imem_req_valid), 64'h0);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        checkOutput("full_no_third_req", 64'(imem_bus.imem_req_valid), 64'h0);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 1);
        checkOutput("full_head_pc", d_pc, 64'h8);
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
        checkOutput("after_pop_pc",    d_pc,                  64'hC);
        checkOutput("after_pop_inst",  64'(d_inst_word),      64'(inst_of(3)));
        checkOutput("after_pop_full",  64'(inst_buffer_full), 64'h0);
        checkOutput("resume_req_addr", imem_bus.imem_req_addr, 64'h10);

        // Redirect to 0x103 while WAIT with a non-empty buffer.
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        checkOutput("pre_redir_d_valid", 64'(d_valid), 64'h1);
        applyStimulus(1, 64'h103, 1, 0, 32'h0, 1);
        applyStimulus(0, 64'h0, 1, 1, inst_of(4), 0);
        checkOutput("redir_flush_empty", 64'(inst_buffer_empty),       64'h1);
        checkOutput("drain_req_valid",   64'(imem_bus.imem_req_valid), 64'h0);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        checkOutput("drain_discard_empty", 64'(inst_buffer_empty),  64'h1);
        checkOutput("redir_req_addr",      imem_bus.imem_req_addr,  64'h100);

        // Redirect to 0x200 in the same cycle as the response.
        applyStimulus(1, 64'h200, 1, 1, inst_of(5), 0);
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
        checkOutput("rsp_redir_empty",     64'(inst_buffer_empty),       64'h1);
        checkOutput("rsp_redir_req_valid", 64'(imem_bus.imem_req_valid), 64'h1);
        checkOutput("rsp_redir_req_addr",  imem_bus.imem_req_addr,       64'h200);

        // Memory not ready for 5 cycles, then redirect to 0x40 in REQ.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
            checkOutput("stall_addr_stable", imem_bus.imem_req_addr, 64'h200);
        end
        applyStimulus(1, 64'h40, 0, 0, 32'h0, 0);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        checkOutput("req_redir_valid", 64'(imem_bus.imem_req_valid), 64'h1);
        checkOutput("req_redir_addr",  imem_bus.imem_req_addr,       64'h40);
        applyStimulus(0, 64'h0, 0, 1, inst_of(6), 0);
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 1);
        checkOutput("req_redir_d_pc",   d_pc,             64'h40);
        checkOutput("req_redir_d_inst", 64'(d_inst_word), 64'(inst_of(6)));

        // Redirect to 0x80 together with a handshake: DRAIN swallows one response.
        applyStimulus(1, 64'h80, 1, 0, 32'h0, 0);
        checkOutput("hs_redir_addr", imem_bus.imem_req_addr, 64'h44);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        checkOutput("drain_hold_valid", 64'(imem_bus.imem_req_valid), 64'h0);
        applyStimulus(0, 64'h0, 0, 1, inst_of(7), 0);
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
        checkOutput("drain_exit_addr",  imem_bus.imem_req_addr, 64'h80);
        checkOutput("drain_exit_empty", 64'(inst_buffer_empty), 64'h1);

        // Address wrap at the top of the address space.
        applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h0, 0);
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        checkOutput("wrap_req_addr", imem_bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(0, 64'h0, 0, 1, inst_of(8), 0);
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
        checkOutput("wrap_d_pc",     d_pc,                   64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap_d_pc4",    d_pc4,                  64'h0);
        checkOutput("wrap_next_req", imem_bus.imem_req_addr, 64'h0);

        // A response while in REQ is ignored.
        applyStimulus(0, 64'h0, 0, 1, inst_of(9), 0);
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
        checkOutput("stray_rsp_not_full", 64'(inst_buffer_full), 64'h0);
        checkOutput("stray_rsp_head_pc",  d_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset with a request outstanding.
        applyStimulus(0, 64'h0, 1, 0, 32'h0, 0);
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_req_valid", 64'(imem_bus.imem_req_valid), 64'h0);
        applyStimulus(0, 64'h0, 0, 0, 32'h0, 0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_empty",     64'(inst_buffer_empty),       64'h1);
        checkOutput("post_rst_req_valid", 64'(imem_bus.imem_req_valid), 64'h1);
        checkOutput("post_rst_req_addr",  imem_bus.imem_req_addr,       64'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
